// File: rtl/sa_act_skewer_if.sv
// Activation input stream for the systolic-array skewer.
// The master drives vectors in; the slave (skewer) returns s_ready.
interface sa_act_skewer_if #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 4
) ();
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_last;
    logic [ROWS*DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_last,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_last,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/sa_act_skewer.sv
// Activation skewer feeding the left edge of the systolic MAC array.
// Each accepted vector is pushed into a shared slot register, then lane r
// delays it by a further r+1 registers, producing the diagonal wavefront.
// A per-lane valid bit travels with the data. Bubbles (zero data, valid=0)
// are pushed on every cycle without an accept; the chains never stall.
// Optional macro SA_SKEW_BUBBLE_CNT_EN enables the input-starvation counter
// on bubble_cnt; without it bubble_cnt is tied to zero.
module sa_act_skewer #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    sa_act_skewer_if.slave         s,
    output logic [ROWS*DATA_W-1:0] a_out,
    output logic [ROWS-1:0]        a_vld,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            bubble_cnt
);

    localparam int                 CNT_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]   FLUSH_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       flush_cnt;
    logic                   accept;
    logic                   done_pre;
    logic [ROWS*DATA_W-1:0] slot_d;
    logic                   slot_v;

    // s_ready is combinational because hold must gate acceptance in the
    // same cycle; rst is included so the port reads 0 while in reset.
    assign s.s_ready = !rst && ((state == STREAM) || ((state == IDLE) && !hold));
    assign accept    = s.s_valid && s.s_ready;

    // Frame FSM with flush counter, registered busy/done and sticky error.
    // done_pre marks the edge before lane ROWS-1 shows the last vector, so the
    // registered done lines up with that lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done_pre  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            busy     <= (state != IDLE);
            done     <= done_pre;
            done_pre <= 1'b0;
            if (hold && (state != IDLE)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (s.s_last) begin
                            if (ROWS > 1) begin
                                state     <= FLUSH;
                                flush_cnt <= FLUSH_LOAD;
                            end else begin
                                state    <= IDLE;
                                done_pre <= 1'b1;
                            end
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state    <= IDLE;
                        done_pre <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_LAST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared push slot: accepted data with valid, otherwise a zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_d <= '0;
            slot_v <= 1'b0;
        end else begin
            slot_d <= accept ? s.s_data : '0;
            slot_v <= accept;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W-1:0] d_q [r+1];
        logic              v_q [r+1];

        // Lane r delay chain of r+1 stages for data and valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned k = 0; k <= r; k++) begin
                    d_q[k] <= '0;
                    v_q[k] <= 1'b0;
                end
            end else begin
                d_q[0] <= slot_d[r*DATA_W +: DATA_W];
                v_q[0] <= slot_v;
                for (int unsigned k = 1; k <= r; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign a_out[r*DATA_W +: DATA_W] = d_q[r];
        assign a_vld[r]                  = v_q[r];
    end

`ifdef SA_SKEW_BUBBLE_CNT_EN
    logic [15:0] bub_q;

    // Starvation counter: STREAM cycles with no input, cleared on a frame's
    // first accept, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bub_q <= '0;
        end else if ((state == IDLE) && accept) begin
            bub_q <= '0;
        end else if ((state == STREAM) && !s.s_valid && (bub_q != '1)) begin
            bub_q <= bub_q + 16'd1;
        end
    end

    assign bubble_cnt = bub_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_act_skewer.sv
// Self-checking bench for sa_act_skewer (ROWS=4, DATA_W=4).
// A history of pushed slots indexed by clock edge predicts every output:
// lane r after edge n shows the slot pushed at edge n-1-r; done follows the
// last accept by ROWS edges. Directed scenarios add literal expectations.
module tb_sa_act_skewer;

    localparam int ROWS   = 4;
    localparam int DATA_W = 4;
    localparam int W      = ROWS * DATA_W;
    localparam int HIST   = 4096;

    typedef enum int { M_IDLE, M_STREAM, M_FLUSH } mmode_t;

    logic clk = 1'b0;
    logic rst;
    logic hold;

    logic [W-1:0]    a_out;
    logic [ROWS-1:0] a_vld;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     bubble_cnt;

    sa_act_skewer_if #(.ROWS(ROWS), .DATA_W(DATA_W)) sif ();

    sa_act_skewer #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .s          (sif.slave),
        .a_out      (a_out),
        .a_vld      (a_vld),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           n;
    int           reset_at;
    int           idle_from;
    bit           open_frame;
    bit           m_busy;
    bit           m_err;
    int unsigned  m_bub;
    logic [W-1:0] push_d  [HIST];
    logic         push_v  [HIST];
    logic         last_at [HIST];

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic mmode_t cur_mode();
        if (open_frame)     return M_STREAM;
        if (n < idle_from)  return M_FLUSH;
        return M_IDLE;
    endfunction

    function automatic logic exp_ready();
        mmode_t md;
        md = cur_mode();
        if (rst)              return 1'b0;
        if (md == M_STREAM)   return 1'b1;
        if (md == M_IDLE)     return !hold;
        return 1'b0;
    endfunction

    task automatic check_model();
        logic [W-1:0]    ed;
        logic [ROWS-1:0] ev;
        logic            edn;
        logic            eby;
        logic            eer;
        logic            erd;
        logic [15:0]     eb;
        int              e;
        ed  = '0;
        ev  = '0;
        edn = 1'b0;
        eby = 1'b0;
        eer = 1'b0;
        erd = 1'b0;
        eb  = '0;
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                e = n - 1 - r;
                if (e > reset_at) begin
                    ed[r*DATA_W +: DATA_W] = push_d[e][r*DATA_W +: DATA_W];
                    ev[r]                  = push_v[e];
                end
            end
            e = n - ROWS;
            if (e > reset_at) edn = last_at[e];
            eby = m_busy;
            eer = m_err;
            erd = exp_ready();
`ifdef SA_SKEW_BUBBLE_CNT_EN
            eb = 16'(m_bub);
`endif
        end
        chk("a_out", 32'(a_out), 32'(ed));
        chk("a_vld", 32'(a_vld), 32'(ev));
        chk("done", 32'(done), 32'(edn));
        chk("busy", 32'(busy), 32'(eby));
        chk("err", 32'(err), 32'(eer));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(eb));
        chk("s_ready", 32'(sif.s_ready), 32'(erd));
    endtask

    task automatic update_model();
        mmode_t md;
        logic   acc;
        md  = cur_mode();
        acc = sif.s_valid && exp_ready();
        n++;
        if (n >= HIST) begin
            $display("FAIL history: edge index %0d exceeds %0d", n, HIST);
            failures++;
            $fatal(1, "history overflow");
        end
        if (rst) begin
            reset_at   = n;
            push_d[n]  = '0;
            push_v[n]  = 1'b0;
            last_at[n] = 1'b0;
            open_frame = 1'b0;
            idle_from  = 0;
            m_busy     = 1'b0;
            m_err      = 1'b0;
            m_bub      = 0;
            return;
        end
        m_busy = (md != M_IDLE);
        if (hold && (md != M_IDLE)) m_err = 1'b1;
        if ((md == M_IDLE) && acc) m_bub = 0;
        else if ((md == M_STREAM) && !sif.s_valid && (m_bub < 65535)) m_bub++;
        push_d[n]  = acc ? sif.s_data : '0;
        push_v[n]  = acc;
        last_at[n] = acc && sif.s_last;
        if (acc) begin
            if (sif.s_last) begin
                open_frame = 1'b0;
                idle_from  = n + ROWS - 1;
            end else begin
                open_frame = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic l, input logic [W-1:0] d, input logic h);
        sif.s_valid = v;
        sif.s_last  = l;
        sif.s_data  = d;
        hold        = h;
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Single-vector frame 16'h4321 with hand-computed diagonal.
    task automatic scen_single();
        logic [W-1:0] exp_out [4];
        logic [3:0]   exp_vld [4];
        logic         exp_busy [4];
        exp_out[0] = 16'h0001; exp_vld[0] = 4'b0001; exp_busy[0] = 1'b1;
        exp_out[1] = 16'h0020; exp_vld[1] = 4'b0010; exp_busy[1] = 1'b1;
        exp_out[2] = 16'h0300; exp_vld[2] = 4'b0100; exp_busy[2] = 1'b1;
        exp_out[3] = 16'h4000; exp_vld[3] = 4'b1000; exp_busy[3] = 1'b0;
        step(1'b1, 1'b1, 16'h4321, 1'b0);
        chk("A_busy_T", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("A_a_out", 32'(a_out), 32'(exp_out[k]));
            chk("A_a_vld", 32'(a_vld), 32'(exp_vld[k]));
            chk("A_busy", 32'(busy), 32'(exp_busy[k]));
            chk("A_done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        chk("A_done_after", 32'(done), 32'd0);
        chk("A_vld_after", 32'(a_vld), 32'd0);
    endtask

    initial begin
        logic [3:0] vseq [7];
        logic       v;
        logic       l;
        checks     = 0;
        failures   = 0;
        n          = 0;
        reset_at   = 0;
        idle_from  = 0;
        open_frame = 1'b0;
        m_busy     = 1'b0;
        m_err      = 1'b0;
        m_bub      = 0;
        for (int i = 0; i < HIST; i++) begin
            push_d[i]  = '0;
            push_v[i]  = 1'b0;
            last_at[i] = 1'b0;
        end
        rst         = 1'b1;
        hold        = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = '0;

        idle(3);
        rst = 1'b0;
        #1;
        chk("R_a_out", 32'(a_out), 32'd0);
        chk("R_a_vld", 32'(a_vld), 32'd0);
        chk("R_busy", 32'(busy), 32'd0);
        chk("R_done", 32'(done), 32'd0);
        chk("R_err", 32'(err), 32'd0);
        chk("R_s_ready", 32'(sif.s_ready), 32'd1);
        idle(2);

        // Scenario A: single-vector frame.
        scen_single();
        idle(2);

        // Scenario B: three back-to-back vectors.
        vseq[0] = 4'b0001; vseq[1] = 4'b0011; vseq[2] = 4'b0111; vseq[3] = 4'b1110;
        vseq[4] = 4'b1100; vseq[5] = 4'b1000; vseq[6] = 4'b0000;
        step(1'b1, 1'b0, 16'h1111, 1'b0);
        step(1'b1, 1'b0, 16'h2222, 1'b0);
        chk("B_vld", 32'(a_vld), 32'(vseq[0]));
        step(1'b1, 1'b1, 16'h3333, 1'b0);
        chk("B_vld", 32'(a_vld), 32'(vseq[1]));
        for (int k = 2; k < 7; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("B_vld", 32'(a_vld), 32'(vseq[k]));
            chk("B_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
            if (k == 3) chk("B_diag", 32'(a_out), 32'h1230);
        end
        idle(2);

        // Scenario C: two-cycle stall between vectors 1 and 2.
        step(1'b1, 1'b0, 16'h1111, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 16'h2222, 1'b0);
        step(1'b1, 1'b1, 16'h3333, 1'b0);
        idle(3);
        chk("C_done_early", 32'(done), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("C_done", 32'(done), 32'd1);
`ifdef SA_SKEW_BUBBLE_CNT_EN
        chk("C_bubble_cnt", 32'(bubble_cnt), 32'd2);
`else
        chk("C_bubble_cnt", 32'(bubble_cnt), 32'd0);
`endif
        idle(2);

        // Scenario D: hold in IDLE blocks acceptance.
        step(1'b1, 1'b1, 16'h5a5a, 1'b1);
        step(1'b1, 1'b1, 16'h5a5a, 1'b1);
        chk("D_s_ready", 32'(sif.s_ready), 32'd0);
        chk("D_busy", 32'(busy), 32'd0);
        chk("D_a_vld", 32'(a_vld), 32'd0);
        step(1'b1, 1'b1, 16'h5a5a, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("D_a_vld_acc", 32'(a_vld), 32'b0001);
        chk("D_a_out_acc", 32'(a_out), 32'h000a);
        idle(5);
        chk("D_err", 32'(err), 32'd0);

        // Scenario E: hold during STREAM raises sticky err.
        step(1'b1, 1'b0, 16'h1111, 1'b0);
        step(1'b1, 1'b0, 16'h2222, 1'b1);
        chk("E_err_set", 32'(err), 32'd1);
        step(1'b1, 1'b1, 16'h3333, 1'b0);
        idle(6);
        chk("E_err_sticky", 32'(err), 32'd1);

        // Scenario F: async reset during FLUSH, then a clean frame.
        step(1'b1, 1'b1, 16'h4321, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("F_pre_vld", 32'(a_vld), 32'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("F_async_out", 32'(a_out), 32'd0);
        chk("F_async_vld", 32'(a_vld), 32'd0);
        chk("F_async_busy", 32'(busy), 32'd0);
        chk("F_async_err", 32'(err), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("F_no_done", 32'(done), 32'd0);
        end
        scen_single();
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                step(1'b0, 1'b0, '0, 1'b0);
                rst = 1'b0;
            end
            v = ($urandom_range(0, 99) < 70);
            l = v && ($urandom_range(0, 3) == 0);
            step(v, l, W'($urandom), ($urandom_range(0, 99) < 8));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
